key_report_tracker: RTL

//  Producer of the key0/key1 movement-keycode pair consumed by the paddle movement logic.

---
 rtl/pong_keys_pkg.sv | 30 +++
 rtl/key_report_tracker_if.sv | 27 ++
 rtl/key_slot_decode.sv | 37 +++
 rtl/key_report_tracker.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pong_keys_pkg.sv
// Shared types and keycode constants for the movement-key tracker.
// Key indices, list entries and tracker states live here.
package pong_keys_pkg;

    typedef enum logic [1:0] {
        KEY_L,
        KEY_R,
        KEY_D,
        KEY_U
    } key_idx_t;

    localparam logic [7:0] DEF_KEY_LEFT  = 8'h04;
    localparam logic [7:0] DEF_KEY_RIGHT = 8'h07;
    localparam logic [7:0] DEF_KEY_DOWN  = 8'h22;
    localparam logic [7:0] DEF_KEY_UP    = 8'h26;
    localparam logic [7:0] KEY_NONE      = 8'h00;
    localparam logic [7:0] HID_ROLLOVER  = 8'h01;

    typedef struct packed {
        logic     v;
        key_idx_t k;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        ACTIVE,
        STALE
    } trk_state_t;

endpackage

// File: rtl/key_report_tracker_if.sv
// Keyboard-report input and movement-keycode output bundle.
// The report source is the master; the tracker is the slave.
interface key_report_tracker_if;

    logic        report_valid;
    logic [47:0] report_keys;
    logic [7:0]  key0;
    logic [7:0]  key1;
    logic        stale;

    modport master (
        output report_valid,
        output report_keys,
        input  key0,
        input  key1,
        input  stale
    );

    modport slave (
        input  report_valid,
        input  report_keys,
        output key0,
        output key1,
        output stale
    );

endinterface

// File: rtl/key_slot_decode.sv
// Combinational decode of a 6-slot HID report into a held mask,
// the first slot each movement key occupies, and the rollover flag.
module key_slot_decode
    import pong_keys_pkg::*;
#(
    parameter logic [7:0] KEY_LEFT  = DEF_KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT = DEF_KEY_RIGHT,
    parameter logic [7:0] KEY_DOWN  = DEF_KEY_DOWN,
    parameter logic [7:0] KEY_UP    = DEF_KEY_UP
) (
    input  logic [47:0]      report_keys,
    output logic [3:0]       held,
    output logic [3:0][2:0]  first_slot,
    output logic             rollover
);

    localparam logic [3:0][7:0] CODES =
        {KEY_UP, KEY_DOWN, KEY_RIGHT, KEY_LEFT};

    // Walk slots high to low so the lowest matching slot wins.
    always_comb begin
        held       = '0;
        first_slot = {4{3'd7}};
        rollover   = 1'b1;
        for (int s = 5; s >= 0; s--) begin
            if (report_keys[8*s +: 8] != HID_ROLLOVER)
                rollover = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (report_keys[8*s +: 8] == CODES[k]) begin
                    held[k]       = 1'b1;
                    first_slot[k] = 3'(s);
                end
            end
        end
    end

endmodule

// File: rtl/key_report_tracker.sv
// Tracks held movement keys in press order from HID reports and
// drives the newest two as key0/key1, dropping them on report timeout.
module key_report_tracker
    import pong_keys_pkg::*;
#(
    parameter logic [7:0] KEY_LEFT     = DEF_KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT    = DEF_KEY_RIGHT,
    parameter logic [7:0] KEY_DOWN     = DEF_KEY_DOWN,
    parameter logic [7:0] KEY_UP       = DEF_KEY_UP,
    parameter int         STALE_FRAMES = 120
) (
    input logic                 frame_clk,
    input logic                 Reset,
    key_report_tracker_if.slave bus
);

    localparam logic [3:0][7:0] CODES =
        {KEY_UP, KEY_DOWN, KEY_RIGHT, KEY_LEFT};
    // The drop happens on the edge that would bring the count to STALE_FRAMES-1.
    localparam logic [9:0] TIMEOUT_AT = 10'(STALE_FRAMES - 2);

    function automatic logic [7:0] code_of(entry_t e);
        if (e.v)
            return CODES[e.k];
        return KEY_NONE;
    endfunction

    logic [3:0]      held;
    logic [3:0][2:0] first_slot;
    logic            rollover;

    key_slot_decode #(
        .KEY_LEFT  (KEY_LEFT),
        .KEY_RIGHT (KEY_RIGHT),
        .KEY_DOWN  (KEY_DOWN),
        .KEY_UP    (KEY_UP)
    ) u_decode (
        .report_keys (bus.report_keys),
        .held        (held),
        .first_slot  (first_slot),
        .rollover    (rollover)
    );

    trk_state_t    state_q, state_d;
    entry_t [3:0]  list_q, list_d;
    logic [9:0]    cnt_q, cnt_d;
    logic          stale_q, stale_d;
    logic [7:0]    key0_q, key0_d;
    logic [7:0]    key1_q, key1_d;

    entry_t [3:0]  kept, fresh, merged;
    logic [2:0]    nk, nf;
    logic [3:0]    inlist, fresh_mask;
    logic          report;

    always_comb begin
        kept   = '0;
        fresh  = '0;
        merged = '0;
        nk     = 3'd0;
        nf     = 3'd0;
        inlist = '0;
        for (int i = 0; i < 4; i++) begin
            inlist[list_q[i].k] = inlist[list_q[i].k] | list_q[i].v;
            if (list_q[i].v && held[list_q[i].k]) begin
                kept[nk[1:0]] = list_q[i];
                nk = nk + 3'd1;
            end
        end
        fresh_mask = held & ~inlist;
        // New presses enter the front in slot order.
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 4; k++) begin
                if (fresh_mask[k] && first_slot[k] == 3'(s)) begin
                    fresh[nf[1:0]] = '{v: 1'b1, k: key_idx_t'(k[1:0])};
                    nf = nf + 3'd1;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nf)
                merged[i] = fresh[i];
            else
                merged[i] = kept[2'(3'(i) - nf)];
        end
    end

    assign report = bus.report_valid && !rollover;

    always_comb begin
        state_d = state_q;
        list_d  = list_q;
        cnt_d   = cnt_q;
        stale_d = stale_q;
        key0_d  = key0_q;
        key1_d  = key1_q;
        if (report) begin
            list_d  = merged;
            cnt_d   = '0;
            stale_d = 1'b0;
            key0_d  = code_of(merged[0]);
            key1_d  = code_of(merged[1]);
            state_d = merged[0].v ? ACTIVE : EMPTY;
        end else if (!bus.report_valid) begin
            unique case (state_q)
                ACTIVE: begin
                    if (cnt_q == TIMEOUT_AT) begin
                        list_d  = '0;
                        key0_d  = KEY_NONE;
                        key1_d  = KEY_NONE;
                        stale_d = 1'b1;
                        cnt_d   = cnt_q + 10'd1;
                        state_d = STALE;
                    end else if (cnt_q != 10'h3FF) begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                EMPTY: ;
                STALE: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= EMPTY;
            list_q  <= '0;
            cnt_q   <= '0;
            stale_q <= 1'b0;
            key0_q  <= KEY_NONE;
            key1_q  <= KEY_NONE;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
            key0_q  <= key0_d;
            key1_q  <= key1_d;
        end
    end

    assign bus.key0  = key0_q;
    assign bus.key1  = key1_q;
    assign bus.stale = stale_q;

endmodule
